// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encodings and frame constants.
// Optional build macro UART_RX_FRAME_CHECK_EN is consumed by uart_top.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int NB_TICK    = $clog2(OVERSAMPLE);
  localparam int NB_BITS    = $clog2(DATA_BITS);

  localparam logic [NB_TICK-1:0] TICK_MID  = NB_TICK'(OVERSAMPLE/2 - 1);
  localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_BITS-1:0] BIT_LAST  = NB_BITS'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Writes when full and reads when empty are dropped.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_rd,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_empty,
  output logic               o_full
);

  localparam int DEPTH = 2**NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wptr;
  logic [NB_ADDR-1:0] rptr;
  logic [NB_ADDR-1:0] wptr_nxt;
  logic [NB_ADDR-1:0] rptr_nxt;
  logic               do_wr;
  logic               do_rd;

  assign do_wr    = i_wr && !o_full;
  assign do_rd    = i_rd && !o_empty;
  assign wptr_nxt = wptr + NB_ADDR'(1);
  assign rptr_nxt = rptr + NB_ADDR'(1);
  assign o_rdata  = mem[rptr];

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr    <= '0;
      rptr    <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= i_wdata;
        wptr      <= wptr_nxt;
      end
      if (do_rd) begin
        rptr <= rptr_nxt;
      end
      if (do_wr && !do_rd) begin
        o_empty <= 1'b0;
        o_full  <= (wptr_nxt == rptr);
      end else if (do_rd && !do_wr) begin
        o_full  <= 1'b0;
        o_empty <= (rptr_nxt == wptr);
      end
    end
  end

endmodule

// File: rtl/uart_top.sv
// UART 8N1 with baud generator, RX/TX FSMs and RX/TX FIFOs.
// Define UART_RX_FRAME_CHECK_EN to drop bytes with a bad stop bit.
module uart_top
  import uart_pkg::*;
#(
  parameter int NB_COUNTER   = 9,
  parameter int NB_DATA      = 8,
  parameter int NB_FIFO_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [NB_COUNTER-1:0] i_tick_cmp,
  input  logic                  i_rx,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic [NB_DATA-1:0]    i_wdata,
  input  logic                  i_tx_start,
  output logic                  o_tx,
  output logic                  o_tx_done,
  output logic                  o_tx_empty,
  output logic                  o_tx_full,
  output logic [NB_DATA-1:0]    o_rdata,
  output logic                  o_rx_done,
  output logic                  o_rx_empty,
  output logic                  o_rx_full
);

  logic [NB_COUNTER-1:0] baud_cnt;
  logic                  tick;

  assign tick = (baud_cnt == i_tick_cmp - NB_COUNTER'(1));

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + NB_COUNTER'(1);
    end
  end

  // i_rx is asynchronous to clk
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t          rx_state;
  logic [NB_TICK-1:0] rx_s;
  logic [NB_BITS-1:0] rx_n;
  logic [NB_DATA-1:0] rx_shift;
  logic               rx_done_q;
  logic               stop_ok;

`ifdef UART_RX_FRAME_CHECK_EN
  assign stop_ok = rx_sync;
`else
  assign stop_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_state  <= RX_IDLE;
      rx_s      <= '0;
      rx_n      <= '0;
      rx_shift  <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_s     <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_s == TICK_MID) begin
              rx_s <= '0;
              rx_n <= '0;
              rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              rx_s <= rx_s + NB_TICK'(1);
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_s == TICK_LAST) begin
              rx_s     <= '0;
              rx_shift <= {rx_sync, rx_shift[NB_DATA-1:1]};
              if (rx_n == BIT_LAST) begin
                rx_state <= RX_STOP;
              end else begin
                rx_n <= rx_n + NB_BITS'(1);
              end
            end else begin
              rx_s <= rx_s + NB_TICK'(1);
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_s == TICK_LAST) begin
              rx_state  <= RX_IDLE;
              rx_done_q <= stop_ok && !o_rx_full;
            end else begin
              rx_s <= rx_s + NB_TICK'(1);
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_done = rx_done_q;

  uart_fifo #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_FIFO_ADDR)
  ) u_rx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wr    (rx_done_q),
    .i_wdata (rx_shift),
    .i_rd    (i_rd),
    .o_rdata (o_rdata),
    .o_empty (o_rx_empty),
    .o_full  (o_rx_full)
  );

  tx_state_t          tx_state;
  logic [NB_TICK-1:0] tx_s;
  logic [NB_BITS-1:0] tx_n;
  logic [NB_DATA-1:0] tx_shift;
  logic [NB_DATA-1:0] tx_head;
  logic               tx_q;
  logic               tx_done_q;
  logic               draining;
  logic               tx_pop;

  assign tx_pop = (tx_state == TX_IDLE) && draining && !o_tx_empty;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      draining <= 1'b0;
    end else if ((tx_state == TX_IDLE) && draining && o_tx_empty) begin
      draining <= 1'b0;
    end else if (i_tx_start && !o_tx_empty && !draining) begin
      draining <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_state  <= TX_IDLE;
      tx_s      <= '0;
      tx_n      <= '0;
      tx_shift  <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (tx_state)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_s     <= '0;
            tx_q     <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            if (tx_s == TICK_LAST) begin
              tx_s     <= '0;
              tx_n     <= '0;
              tx_q     <= tx_shift[0];
              tx_state <= TX_DATA;
            end else begin
              tx_s <= tx_s + NB_TICK'(1);
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_s == TICK_LAST) begin
              tx_s <= '0;
              if (tx_n == BIT_LAST) begin
                tx_q     <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                tx_n     <= tx_n + NB_BITS'(1);
                tx_shift <= tx_shift >> 1;
                tx_q     <= tx_shift[1];
              end
            end else begin
              tx_s <= tx_s + NB_TICK'(1);
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tx_s == TICK_LAST) begin
              tx_done_q <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              tx_s <= tx_s + NB_TICK'(1);
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = tx_done_q;

  uart_fifo #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_FIFO_ADDR)
  ) u_tx_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wr    (i_wr),
    .i_wdata (i_wdata),
    .i_rd    (tx_pop),
    .o_rdata (tx_head),
    .o_empty (o_tx_empty),
    .o_full  (o_tx_full)
  );

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: queue-based FIFO model plus serial line monitor.
module tb_uart_top;
  import uart_pkg::*;

  localparam int CMP   = 4;
  localparam int BIT   = 16 * CMP;
  localparam int DEPTH = 16;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst;
  logic [8:0] i_tick_cmp;
  logic       i_rx, i_rd, i_wr, i_tx_start;
  logic [7:0] i_wdata;
  logic       o_tx, o_tx_done, o_tx_empty, o_tx_full;
  logic [7:0] o_rdata;
  logic       o_rx_done, o_rx_empty, o_rx_full;

  always #5 clk = ~clk;

  uart_top dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_tick_cmp (i_tick_cmp),
    .i_rx       (i_rx),
    .i_rd       (i_rd),
    .i_wr       (i_wr),
    .i_wdata    (i_wdata),
    .i_tx_start (i_tx_start),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_tx_empty (o_tx_empty),
    .o_tx_full  (o_tx_full),
    .o_rdata    (o_rdata),
    .o_rx_done  (o_rx_done),
    .o_rx_empty (o_rx_empty),
    .o_rx_full  (o_rx_full)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] txlog[$];
  int exp_rx_done = 0;
  int rx_done_cnt = 0;
  int tx_done_cnt = 0;
  int tx_frames   = 0;
  bit chk_en = 1'b0;
  logic rx_done_prev = 1'b0;
  logic tx_done_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst) begin
      if (o_rx_done) rx_done_cnt++;
      if (o_tx_done) tx_done_cnt++;
      check("rx_done_width", {31'd0, o_rx_done & rx_done_prev}, 0);
      check("tx_done_width", {31'd0, o_tx_done & tx_done_prev}, 0);
      check("rx_flags_excl", {31'd0, o_rx_full & o_rx_empty}, 0);
      check("tx_flags_excl", {31'd0, o_tx_full & o_tx_empty}, 0);
      if (chk_en) begin
        check("rx_empty", o_rx_empty, rxq.size() == 0);
        check("rx_full", o_rx_full, rxq.size() == DEPTH);
        if (rxq.size() > 0) check("rdata", o_rdata, rxq[0]);
      end
    end
    rx_done_prev = o_rx_done;
    tx_done_prev = o_tx_done;
  end

  task automatic mon_wait(int n, inout bit alive);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!i_rst) alive = 1'b0;
    end
  endtask

  task automatic decode_frame();
    bit alive = 1'b1;
    logic [7:0] b = '0;
    logic stop_bit;
    mon_wait(BIT + BIT/4, alive);
    for (int k = 0; k < 8; k++) begin
      b[k] = o_tx;
      mon_wait(BIT, alive);
    end
    stop_bit = o_tx;
    if (alive) begin
      check("tx_stop_bit", stop_bit, 1);
      tests++;
      if (txq.size() == 0) begin
        fails++;
        $display("FAIL tx_frame: got unexpected byte %0h, expected none", b);
      end else if (b !== txq[0]) begin
        fails++;
        $display("FAIL tx_frame: got %0h, expected %0h", b, txq[0]);
      end
      if (txq.size() > 0) void'(txq.pop_front());
      txlog.push_back(b);
      tx_frames++;
    end
  endtask

  initial begin : tx_mon
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !o_tx) decode_frame();
        prev = o_tx;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    chk_en = 1'b0;
    i_rx = 1'b0;
    step(BIT);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      step(BIT);
    end
    if (stop) begin
      i_rx = 1'b1;
      step(BIT);
    end else begin
      i_rx = 1'b0;
      step(12 * CMP);
      i_rx = 1'b1;
      step(4 * CMP + BIT);
    end
    if ((stop || !FC) && rxq.size() < DEPTH) begin
      rxq.push_back(b);
      exp_rx_done++;
    end
    step(2);
    chk_en = 1'b1;
  endtask

  task automatic rd_rx();
    chk_en = 1'b0;
    i_rd = 1'b1;
    step(1);
    i_rd = 1'b0;
    if (rxq.size() > 0) void'(rxq.pop_front());
    chk_en = 1'b1;
  endtask

  task automatic drain_rx();
    while (rxq.size() > 0) rd_rx();
    step(1);
    check("rx_drained_empty", o_rx_empty, 1);
  endtask

  task automatic wr_tx(input logic [7:0] b);
    i_wr = 1'b1;
    i_wdata = b;
    step(1);
    i_wr = 1'b0;
    if (txq.size() < DEPTH) txq.push_back(b);
  endtask

  task automatic pulse_start();
    i_tx_start = 1'b1;
    step(1);
    i_tx_start = 1'b0;
  endtask

  task automatic wait_tx(int frames, int dones);
    int limit;
    limit = (frames - tx_frames + 1) * BIT * 12;
    for (int c = 0; c < limit; c++) begin
      if (tx_frames >= frames && tx_done_cnt >= dones) break;
      step(1);
    end
    check("tx_frames", tx_frames, frames);
    check("tx_done_cnt", tx_done_cnt, dones);
  endtask

  initial begin : timeout
    #(3ms);
    $display("FAIL timeout: simulation exceeded bound");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] lit [4];
    logic [7:0] b;
    int fr, dn;
    lit[0] = 8'h13; lit[1] = 8'h00; lit[2] = 8'h10; lit[3] = 8'h00;
    i_rst = 1'b0;
    i_tick_cmp = 9'(CMP);
    i_rx = 1'b1; i_rd = 1'b0; i_wr = 1'b0;
    i_wdata = '0; i_tx_start = 1'b0;
    step(3);
    check("rst_tx", o_tx, 1);
    check("rst_tx_done", o_tx_done, 0);
    check("rst_rx_done", o_rx_done, 0);
    check("rst_rx_full", o_rx_full, 0);
    check("rst_tx_full", o_tx_full, 0);
    i_rst = 1'b1;
    step(5);
    check("idle_tx", o_tx, 1);
    check("idle_rx_empty", o_rx_empty, 1);
    check("idle_tx_empty", o_tx_empty, 1);
    check("idle_rdata", o_rdata, 8'h00);
    chk_en = 1'b1;

    send_rx(8'h01, 1'b1);
    check("rx01_done", rx_done_cnt, 1);
    check("rx01_rdata", o_rdata, 8'h01);
    check("rx01_not_empty", o_rx_empty, 0);
    rd_rx();
    step(1);
    check("rx01_empty_after_rd", o_rx_empty, 1);

    for (int i = 0; i < 4; i++) wr_tx(lit[i]);
    check("tx4_not_empty", o_tx_empty, 0);
    pulse_start();
    wait_tx(4, 4);
    for (int i = 0; i < 4; i++) check("tx4_log", txlog[i], lit[i]);
    check("tx4_empty", o_tx_empty, 1);

    pulse_start();
    wr_tx(8'($urandom));
    step(BIT * 12);
    check("tx_start_empty_ignored", tx_frames, 4);
    check("tx_idle_line", o_tx, 1);
    pulse_start();
    wait_tx(5, 5);

    for (int i = 0; i < 18; i++) begin
      wr_tx(8'($urandom));
      if (i == 15) check("tx_full_16", o_tx_full, 1);
    end
    check("tx_full_hold", o_tx_full, 1);
    pulse_start();
    step(BIT * 3);
    pulse_start();
    wait_tx(21, 21);
    check("tx_full_drained", o_tx_empty, 1);
    check("tx_full_cleared", o_tx_full, 0);

    chk_en = 1'b0;
    i_rx = 1'b0;
    step(3 * CMP);
    i_rx = 1'b1;
    step(BIT * 2);
    check("glitch_no_done", rx_done_cnt, exp_rx_done);
    check("glitch_idle", dut.rx_state, RX_IDLE);
    chk_en = 1'b1;

    for (int i = 0; i < 17; i++) begin
      b = (i == 0) ? 8'hC3 : 8'($urandom);
      send_rx(b, 1'b1);
    end
    check("rx17_full", o_rx_full, 1);
    check("rx17_head", o_rdata, 8'hC3);
    check("rx17_done_total", rx_done_cnt, 17);
    drain_rx();

    send_rx(8'hA5, 1'b0);
    check("frame_chk_empty", o_rx_empty, FC);
    check("frame_chk_data", o_rx_empty ? 8'h00 : o_rdata,
          FC ? 8'h00 : 8'hA5);
    check("frame_chk_done", rx_done_cnt, exp_rx_done);
    drain_rx();

    for (int i = 0; i < 4; i++) begin
      send_rx(8'($urandom), 1'($urandom_range(0, 1)));
      check("rx_rand_done", rx_done_cnt, exp_rx_done);
    end
    drain_rx();

    chk_en = 1'b0;
    i_rx = 1'b0;
    step(BIT);
    for (int k = 0; k < 4; k++) begin
      i_rx = k[0];
      step(BIT);
    end
    #2 i_rst = 1'b0;
    #1;
    check("rstmid_rx_done", o_rx_done, 0);
    check("rstmid_rx_empty", o_rx_empty, 1);
    i_rx = 1'b1;
    step(3);
    i_rst = 1'b1;
    step(BIT * 12);
    check("rstmid_rx_no_store", o_rx_empty, 1);
    check("rstmid_rx_cnt", rx_done_cnt, exp_rx_done);
    chk_en = 1'b1;

    fr = tx_frames;
    dn = tx_done_cnt;
    wr_tx(8'h5A);
    pulse_start();
    step(BIT * 4);
    #2 i_rst = 1'b0;
    #1;
    check("rstmid_tx_line", o_tx, 1);
    check("rstmid_tx_empty", o_tx_empty, 1);
    check("rstmid_tx_done", o_tx_done, 0);
    txq.delete();
    step(3);
    i_rst = 1'b1;
    step(BIT * 12);
    check("rstmid_tx_frames", tx_frames, fr);
    check("rstmid_tx_dones", tx_done_cnt, dn);
    check("rstmid_tx_idle", o_tx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
